// File: rtl/accsync_corr.sv
// Receive access-code correlator: slides a 64-bit window over rxbit, declares sync within an
// error threshold, checks the 4-bit trailer and emits header/payload start pulses.
module accsync_corr (
    input  logic        clk_6M,
    input  logic        rstz,
    input  logic        p_1us,
    input  logic        rxbit,
    input  logic        corr_en,
    input  logic [63:0] regi_syncword,
    input  logic [5:0]  regi_corr_thr,
    input  logic [9:0]  regi_search_win,
    input  logic        regi_trailer_chk,
    output logic        corr_busy,
    output logic        sync_found_p,
    output logic        rx_trailer_st_p,
    output logic        rx_header_st_p,
    output logic        trailer_err_p,
    output logic        search_timeout_p,
    output logic [6:0]  rx_sync_errcnt
);

    typedef enum logic [1:0] {IDLE, SEARCH, TRAILER, DONE} state_t;

    state_t      state;
    logic [63:0] sreg;
    logic [6:0]  fill;
    logic [9:0]  win_cnt;
    logic [1:0]  trl_cnt;
    logic        trl_bad;
    logic        hit_eval;
    logic        trl_eval;
    logic [6:0]  err_cnt;
    logic        hit;
    logic        timeout;
    logic        trl_done;
    logic        trl_ok;
    logic        trl_fail;
    logic        exp_trl_bit;

    always_comb begin
        err_cnt = 7'd0;
        for (int i = 0; i < 64; i++) begin
            err_cnt = err_cnt + {6'd0, sreg[i] ^ regi_syncword[i]};
        end
    end

    // Decisions are taken in the cycle after a strobe and gated by corr_en so an enable drop
    // in that same cycle suppresses the pulse.
    assign hit      = corr_en && (state == SEARCH) && hit_eval && (fill == 7'd64) &&
                      (err_cnt <= {1'b0, regi_corr_thr});
    assign timeout  = corr_en && (state == SEARCH) && hit_eval && !hit &&
                      (regi_search_win != 10'd0) && (win_cnt >= regi_search_win);
    assign trl_done = corr_en && (state == TRAILER) && trl_eval;
    assign trl_ok   = trl_done && (!trl_bad || !regi_trailer_chk);
    assign trl_fail = trl_done && trl_bad && regi_trailer_chk;

    assign exp_trl_bit = trl_cnt[0] ? regi_syncword[63] : ~regi_syncword[63];

    assign corr_busy        = (state == SEARCH) || (state == TRAILER);
    assign sync_found_p     = hit;
    assign rx_trailer_st_p  = hit;
    assign rx_header_st_p   = trl_ok;
    assign trailer_err_p    = trl_fail;
    assign search_timeout_p = timeout;

    always_ff @(posedge clk_6M or negedge rstz) begin
        if (!rstz) begin
            state          <= IDLE;
            sreg           <= 64'd0;
            fill           <= 7'd0;
            win_cnt        <= 10'd0;
            trl_cnt        <= 2'd0;
            trl_bad        <= 1'b0;
            hit_eval       <= 1'b0;
            trl_eval       <= 1'b0;
            rx_sync_errcnt <= 7'd0;
        end else begin
            hit_eval <= 1'b0;
            trl_eval <= 1'b0;
            if (!corr_en) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        state   <= SEARCH;
                        fill    <= 7'd0;
                        win_cnt <= 10'd0;
                        trl_cnt <= 2'd0;
                        trl_bad <= 1'b0;
                    end
                    SEARCH: begin
                        if (hit) begin
                            state          <= TRAILER;
                            rx_sync_errcnt <= err_cnt;
                            trl_cnt        <= 2'd0;
                            trl_bad        <= 1'b0;
                        end else if (timeout) begin
                            state <= DONE;
                        end else if (p_1us) begin
                            sreg     <= {rxbit, sreg[63:1]};
                            fill     <= (fill == 7'd64) ? 7'd64 : fill + 7'd1;
                            win_cnt  <= (win_cnt == 10'h3FF) ? win_cnt : win_cnt + 10'd1;
                            hit_eval <= 1'b1;
                        end
                    end
                    TRAILER: begin
                        if (trl_ok) begin
                            state <= DONE;
                        end else if (trl_fail) begin
                            // Window counter keeps running so the search window still bounds retries.
                            state <= SEARCH;
                            fill  <= 7'd0;
                        end else if (p_1us) begin
                            if (rxbit != exp_trl_bit) trl_bad <= 1'b1;
                            trl_cnt <= trl_cnt + 2'd1;
                            if (trl_cnt == 2'd3) trl_eval <= 1'b1;
                        end
                    end
                    DONE: begin
                        state <= DONE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/accsync_corr.md
# accsync_corr

Receive-side access-code correlator for the baseband bit processor. It samples `rxbit` once per microsecond and slides a 64-bit window over the incoming stream. When the window matches the expected sync word within a programmable bit-error threshold, it declares sync. It then checks the 4-bit trailer and emits the start pulses (`rx_trailer_st_p`, `rx_header_st_p`) that time the header and payload decoders downstream.

## Interface
No parameters.
- `clk_6M` in 1: system clock, 6 MHz.
- `rstz` in 1: asynchronous active-low reset.
- `p_1us` in 1: one-cycle bit strobe; `rxbit` is valid when it is high.
- `rxbit` in 1: demodulated receive bit.
- `corr_en` in 1: search enable, level. A rising edge opens a search window.
- `regi_syncword` in 64: expected sync word; bit 0 is transmitted first.
- `regi_corr_thr` in 6: maximum bit errors accepted for a sync hit.
- `regi_search_win` in 10: search window length in bit strobes; 0 means unlimited.
- `regi_trailer_chk` in 1: 1 means a trailer mismatch aborts the packet.
- `corr_busy` out 1: high in any state other than IDLE and DONE.
- `sync_found_p` out 1: one-cycle pulse on a sync hit.
- `rx_trailer_st_p` out 1: one-cycle pulse at trailer start; identical in timing to `sync_found_p`.
- `rx_header_st_p` out 1: one-cycle pulse after the 4th trailer bit, only when the trailer is accepted.
- `trailer_err_p` out 1: one-cycle pulse when the trailer is rejected.
- `search_timeout_p` out 1: one-cycle pulse when the window expires without a hit.
- `rx_sync_errcnt` out 7: bit-error count of the last hit; held until the next hit.

## Operation
- **States:** IDLE, SEARCH, TRAILER, DONE.
- **IDLE → SEARCH:** on the cycle `corr_en` is first seen high. On entry, clear the fill counter (7-bit, saturates at 64), the window counter (10-bit) and the trailer counter.
- **Shift register:** on each `p_1us` in SEARCH, shift `rxbit` in at bit 63 and shift right. After 64 shifts, bit 0 holds the first bit received.
- **Error count:** popcount of (shift register XOR `regi_syncword`), range 0..64, 7 bits.
- **Sync hit:** evaluated in the cycle after each shifting strobe. A hit requires fill = 64 and error count ≤ `regi_corr_thr`.
  - Go to TRAILER.
  - Pulse `sync_found_p` and `rx_trailer_st_p`.
  - Latch `rx_sync_errcnt`.
- **Window count:** each `p_1us` in SEARCH increments the window counter. When `regi_search_win` ≠ 0 and the count reaches `regi_search_win` without a hit, pulse `search_timeout_p` and go to DONE.
- **Trailer check:** expected trailer bits in transmission order are ~s63, s63, ~s63, s63, where s63 = `regi_syncword[63]`.
  - TRAILER samples 4 bits on `p_1us` and records whether any bit mismatched.
  - After the 4th bit, if there was no mismatch or `regi_trailer_chk` = 0: pulse `rx_header_st_p` and go to DONE.
  - Otherwise pulse `trailer_err_p` and go to SEARCH. The fill counter is cleared; the window counter keeps running.
- **DONE:** one search per enable. Stay in DONE until `corr_en` is low, then go to IDLE.
- **Abort:** `corr_en` low in any state forces IDLE on the next clock and suppresses every pulse in that cycle.

## Timing
- **Reset:** all outputs 0, `rx_sync_errcnt` = 0, state IDLE, shift register all 0.
- **Hit latency:** `sync_found_p` and `rx_trailer_st_p` are high exactly one `clk_6M` cycle after the `p_1us` that shifted in the 64th window bit.
- **Header latency:** `rx_header_st_p` is high one cycle after the `p_1us` that carries the 4th trailer bit. This is 4 strobes after the hit.
- **Fill requirement:** no hit is possible before 64 strobes have elapsed since SEARCH entry or since a trailer reject.
- **Hit vs timeout:** if a hit and window expiry fall on the same strobe, the hit wins and there is no timeout pulse.
- **Enable drop:** `corr_en` deasserted in the same cycle as a hit gives no pulse.
- **Re-enable:** a rising edge of `corr_en` while in DONE is ignored. It must fall first.
- **Threshold extremes:**
  - `regi_corr_thr` = 0 requires an exact match.
  - `regi_corr_thr` = 63 hits on any filled window with 63 or fewer errors.
- **Mid-operation reset:** `rstz` low forces IDLE immediately and clears all outputs; no pulse follows release.

## Test plan
- **Exact match:** `regi_syncword` = 64'h4E1C_3A5F_0B27_9D61, `regi_corr_thr` = 0. Stream 10 random bits, then the sync word LSB-first, then trailer 1,0,1,0 (s63 = 0). Required: `sync_found_p` one cycle after the 74th strobe, `rx_sync_errcnt` = 0, `rx_header_st_p` one cycle after the 78th strobe.
- **Error threshold:**
  - With `regi_corr_thr` = 3 and 3 flipped sync bits: hit with `rx_sync_errcnt` = 3.
  - With 4 flipped bits: no hit, and `search_timeout_p` fires at strobe `regi_search_win` = 200.
- **Trailer reject:** trailer 1,1,1,0 with `regi_trailer_chk` = 1. Required: `trailer_err_p` after the 4th trailer bit, no `rx_header_st_p`, return to SEARCH, and a clean second packet is found.
  - With `regi_trailer_chk` = 0 the same stimulus gives `rx_header_st_p`.
- **Fill guard:** shift register holds the sync-word pattern before entry. Enable `corr_en` and feed all-zero bits. Required: no hit within the first 63 strobes.
- **Abort and re-arm:** drop `corr_en` on the hit cycle. Required: no pulses and IDLE next cycle. Re-raise `corr_en`: a new search starts with the fill counter cleared.
- **Unlimited window:** `regi_search_win` = 0 with 1000 strobes of noise gives no `search_timeout_p`. Assert `rstz` low mid-SEARCH: all outputs 0 and state IDLE.
